// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner
//   Time-multiplexed driver for a common-anode/cathode seven-segment display.
//   A free-running divider holds each digit for CLK_DIV cycles; the digit
//   index walks 0..DIGITS-1 and wraps. Segment, decimal point and anode pins
//   are registered from the current index and a shadow copy of the display
//   data, so pins lag an index change by exactly one clock.
//
// Ports
//   clk        in   single rising-edge clock
//   reset      in   synchronous, active-high
//   value      in   [4*DIGITS] hex nibbles, nibble i drives digit i (0 = LSD)
//   dp_in      in   [DIGITS]   decimal-point request per digit
//   load       in   capture strobe for value/dp_in
//   blank_lz   in   leading-zero suppression enable, sampled every cycle
//   seg        out  [7] segments g..a (bit6 = g), registered
//   dp         out  decimal point, registered
//   an         out  [DIGITS] one-hot digit enable, registered
//   frame_done out  one-cycle pulse when the pins show digit 0 after a wrap
//
// Handshake: load is a plain capture strobe with no ready/back-pressure; it
// is accepted on every rising edge where it is 1. With SYNC_LOAD=1 the data
// is parked in a pending register and only reaches the display at the next
// frame boundary; a later load before that boundary overwrites it.
module seven_seg_scanner #(
  parameter int DIGITS     = 4,
  parameter int CLK_DIV    = 50000,
  parameter int ACTIVE_LOW = 0,
  parameter int SYNC_LOAD  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic                  blank_lz,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int VAL_W = 4 * DIGITS;
  localparam bit INV   = (ACTIVE_LOW != 0);

  // "Off" pin levels, used at reset and as the inversion reference.
  localparam logic [6:0]        SEG_OFF = INV ? 7'h7F : 7'h00;
  localparam logic              DP_OFF  = INV;
  localparam logic [DIGITS-1:0] AN_OFF  = INV ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [DIV_W-1:0]  div_q, div_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [VAL_W-1:0]  shadow_q, shadow_d;
  logic [DIGITS-1:0] shadow_dp_q, shadow_dp_d;
  logic [VAL_W-1:0]  pend_q, pend_d;
  logic [DIGITS-1:0] pend_dp_q, pend_dp_d;
  logic              pend_flag_q, pend_flag_d;
  logic              wrap_q, wrap_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic              frame_done_q, frame_done_d;

  logic              div_end, idx_end, wrap;
  logic              all_zero;
  logic [DIGITS-1:0] blank_vec;
  logic [3:0]        nib;
  logic              dp_raw, blank_sel;
  logic [DIGITS-1:0] an_raw;
  logic [6:0]        seg_raw;

  function automatic logic [6:0] decode_hex(input logic [3:0] n);
    logic [6:0] p;
    p = 7'h00;
    case (n)
      4'h0: p = 7'h3F; 4'h1: p = 7'h06; 4'h2: p = 7'h5B; 4'h3: p = 7'h4F;
      4'h4: p = 7'h66; 4'h5: p = 7'h6D; 4'h6: p = 7'h7D; 4'h7: p = 7'h07;
      4'h8: p = 7'h7F; 4'h9: p = 7'h6F; 4'hA: p = 7'h77; 4'hB: p = 7'h7C;
      4'hC: p = 7'h39; 4'hD: p = 7'h5E; 4'hE: p = 7'h79; 4'hF: p = 7'h71;
      default: p = 7'h00;
    endcase
    return p;
  endfunction

  always_comb begin
    // Scan counters.
    div_end = (div_q == DIV_W'(CLK_DIV - 1));
    idx_end = (idx_q == IDX_W'(DIGITS - 1));
    wrap    = div_end && idx_end;
    div_d   = div_end ? '0 : div_q + DIV_W'(1);
    idx_d   = idx_q;
    if (div_end) idx_d = idx_end ? '0 : idx_q + IDX_W'(1);
    wrap_d  = wrap;

    // Display data capture.
    shadow_d    = shadow_q;
    shadow_dp_d = shadow_dp_q;
    pend_d      = pend_q;
    pend_dp_d   = pend_dp_q;
    pend_flag_d = pend_flag_q;
    if (SYNC_LOAD == 0) begin
      if (load) begin
        shadow_d    = value;
        shadow_dp_d = dp_in;
      end
    end else begin
      if (load && wrap) begin
        // Load on the boundary edge goes straight to the display.
        shadow_d    = value;
        shadow_dp_d = dp_in;
        pend_flag_d = 1'b0;
      end else if (wrap) begin
        if (pend_flag_q) begin
          shadow_d    = pend_q;
          shadow_dp_d = pend_dp_q;
        end
        pend_flag_d = 1'b0;
      end else if (load) begin
        pend_d      = value;
        pend_dp_d   = dp_in;
        pend_flag_d = 1'b1;
      end
    end

    // Leading-zero mask: walk from the most significant digit down, a digit
    // is blank while every nibble from the top down to it is zero.
    all_zero  = 1'b1;
    blank_vec = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      all_zero     = all_zero && (shadow_q[4*i +: 4] == 4'h0);
      blank_vec[i] = blank_lz && all_zero && (i != 0);
    end

    // Select the digit under the current index.
    nib       = 4'h0;
    dp_raw    = 1'b0;
    blank_sel = 1'b0;
    an_raw    = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        nib       = shadow_q[4*i +: 4];
        dp_raw    = shadow_dp_q[i];
        blank_sel = blank_vec[i];
        an_raw[i] = 1'b1;
      end
    end
    seg_raw = blank_sel ? 7'h00 : decode_hex(nib);

    // Polarity is applied last; frame_done is never inverted.
    seg_d        = seg_raw ^ SEG_OFF;
    dp_d         = dp_raw ^ DP_OFF;
    an_d         = an_raw ^ AN_OFF;
    frame_done_d = wrap_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q        <= '0;
      idx_q        <= '0;
      shadow_q     <= '0;
      shadow_dp_q  <= '0;
      pend_q       <= '0;
      pend_dp_q    <= '0;
      pend_flag_q  <= 1'b0;
      wrap_q       <= 1'b0;
      seg_q        <= SEG_OFF;
      dp_q         <= DP_OFF;
      an_q         <= AN_OFF;
      frame_done_q <= 1'b0;
    end else begin
      div_q        <= div_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      shadow_dp_q  <= shadow_dp_d;
      pend_q       <= pend_d;
      pend_dp_q    <= pend_dp_d;
      pend_flag_q  <= pend_flag_d;
      wrap_q       <= wrap_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner
//   Four scanner instances with different parameter sets share one stimulus
//   stream. A reference model tracks, per instance, the number of clocks since
//   reset and the displayed/pending data, and derives the expected pins from
//   that count with plain arithmetic. Directed sequences cover the display
//   examples, then a randomized phase follows.
module tb_seven_seg_scanner;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        load;
  logic        blank_lz;
  logic [15:0] value;
  logic [3:0]  dp_in;

  logic [6:0] seg0, seg1, seg2, seg3;
  logic       dp0, dp1, dp2, dp3;
  logic [3:0] an0, an1;
  logic [2:0] an2;
  logic [0:0] an3;
  logic       fd0, fd1, fd2, fd3;

  // u0: plain, u1: frame-synchronous loads, u2: 3 digits active-low, u3: single digit
  seven_seg_scanner #(.DIGITS(4), .CLK_DIV(4), .ACTIVE_LOW(0), .SYNC_LOAD(0)) u0 (
    .clk(clk), .reset(reset), .value(value), .dp_in(dp_in), .load(load),
    .blank_lz(blank_lz), .seg(seg0), .dp(dp0), .an(an0), .frame_done(fd0));
  seven_seg_scanner #(.DIGITS(4), .CLK_DIV(4), .ACTIVE_LOW(0), .SYNC_LOAD(1)) u1 (
    .clk(clk), .reset(reset), .value(value), .dp_in(dp_in), .load(load),
    .blank_lz(blank_lz), .seg(seg1), .dp(dp1), .an(an1), .frame_done(fd1));
  seven_seg_scanner #(.DIGITS(3), .CLK_DIV(3), .ACTIVE_LOW(1), .SYNC_LOAD(0)) u2 (
    .clk(clk), .reset(reset), .value(value[11:0]), .dp_in(dp_in[2:0]), .load(load),
    .blank_lz(blank_lz), .seg(seg2), .dp(dp2), .an(an2), .frame_done(fd2));
  seven_seg_scanner #(.DIGITS(1), .CLK_DIV(2), .ACTIVE_LOW(0), .SYNC_LOAD(0)) u3 (
    .clk(clk), .reset(reset), .value(value[3:0]), .dp_in(dp_in[0:0]), .load(load),
    .blank_lz(blank_lz), .seg(seg3), .dp(dp3), .an(an3), .frame_done(fd3));

  // ---------------- reference model ----------------
  localparam int ND[4] = '{4, 4, 3, 1};
  localparam int CD[4] = '{4, 4, 3, 2};
  localparam bit AL[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  localparam bit SL[4] = '{1'b0, 1'b1, 1'b0, 1'b0};

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int          cnt  [4];
  logic [15:0] sh   [4];
  logic [15:0] pv   [4];
  logic [3:0]  sdp  [4];
  logic [3:0]  pdp  [4];
  bit          have [4];
  logic [16:0] expv [4];
  logic [16:0] got  [4];

  logic [6:0] rec0 [4];
  logic [6:0] rec1 [4];
  int total = 0;
  int bad   = 0;

  // Expected pins for this edge come from the state before the edge; the
  // state then advances by one clock.
  task automatic model_edge();
    for (int k = 0; k < 4; k++) begin
      logic [6:0]  s;
      logic        d;
      logic [7:0]  a;
      logic        f;
      logic [31:0] vmask, dmask, upper, dsh;
      int          idx;
      bit          wrap;
      vmask = (32'd1 << (4 * ND[k])) - 32'd1;
      dmask = (32'd1 << ND[k]) - 32'd1;
      if (reset) begin
        s = 7'h00; d = 1'b0; a = 8'h00; f = 1'b0;
        cnt[k] = 0; sh[k] = '0; sdp[k] = '0; pv[k] = '0; pdp[k] = '0; have[k] = 1'b0;
      end else begin
        idx   = (cnt[k] / CD[k]) % ND[k];
        upper = {16'h0, sh[k]} >> (4 * idx);
        s     = seg_tab[upper[3:0]];
        if (blank_lz && idx != 0 && upper == 32'h0) s = 7'h00;
        dsh   = {28'h0, sdp[k]} >> idx;
        d     = dsh[0];
        a     = 8'd1 << idx;
        f     = (cnt[k] != 0) && (cnt[k] % (CD[k] * ND[k]) == 0);
        wrap  = ((cnt[k] + 1) % (CD[k] * ND[k])) == 0;
        cnt[k]++;
        if (SL[k]) begin
          if (load) begin
            pv[k] = value & vmask[15:0]; pdp[k] = dp_in & dmask[3:0]; have[k] = 1'b1;
          end
          if (wrap && have[k]) begin
            sh[k] = pv[k]; sdp[k] = pdp[k]; have[k] = 1'b0;
          end
        end else if (load) begin
          sh[k] = value & vmask[15:0]; sdp[k] = dp_in & dmask[3:0];
        end
      end
      if (AL[k]) begin
        s = ~s; d = ~d; a = a ^ dmask[7:0];
      end
      expv[k] = {s, d, a, f};
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // Inputs are set by the caller at the falling edge; one call = one clock.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    got[0] = {seg0, dp0, 4'b0, an0, fd0};
    got[1] = {seg1, dp1, 4'b0, an1, fd1};
    got[2] = {seg2, dp2, 5'b0, an2, fd2};
    got[3] = {seg3, dp3, 7'b0, an3, fd3};
    for (int k = 0; k < 4; k++) check_eq($sformatf("pins_u%0d", k), 32'(got[k]), 32'(expv[k]));
    for (int i = 0; i < 4; i++) begin
      if (an0[i]) rec0[i] = seg0;
      if (an1[i]) rec1[i] = seg1;
    end
  endtask

  task automatic clear_rec();
    for (int i = 0; i < 4; i++) begin
      rec0[i] = 7'h55;
      rec1[i] = 7'h55;
    end
  endtask

  task automatic pulse_load(input logic [15:0] v, input logic [3:0] d);
    value = v; dp_in = d; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic wait_phase(input int ph);
    for (int g = 0; g < 40 && (cnt[1] % 16) != ph; g++) step();
    check_eq("phase_reached", 32'(cnt[1] % 16), 32'(ph));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int fcnt;
    reset = 1'b1; load = 1'b0; blank_lz = 1'b0; value = '0; dp_in = '0;
    repeat (3) step();
    check_eq("rst_seg0", 32'(seg0), 32'h00);
    check_eq("rst_an0", 32'(an0), 32'h0);
    check_eq("rst_an2_al", 32'(an2), 32'h7);
    check_eq("rst_seg2_al", 32'(seg2), 32'h7F);
    reset = 1'b0;

    // Scan order and frame pulses.
    clear_rec();
    pulse_load(16'h1A3F, 4'h0);
    fcnt = 0;
    for (int i = 0; i < 64; i++) begin
      step();
      if (fd0) fcnt++;
    end
    check_eq("fd_count", 32'(fcnt), 32'd4);
    check_eq("scan_d0", 32'(rec0[0]), 32'h71);
    check_eq("scan_d1", 32'(rec0[1]), 32'h4F);
    check_eq("scan_d2", 32'(rec0[2]), 32'h77);
    check_eq("scan_d3", 32'(rec0[3]), 32'h06);

    // Leading-zero suppression.
    blank_lz = 1'b1;
    pulse_load(16'h0050, 4'h0);
    clear_rec();
    repeat (20) step();
    check_eq("lz_d0", 32'(rec0[0]), 32'h3F);
    check_eq("lz_d1", 32'(rec0[1]), 32'h6D);
    check_eq("lz_d2", 32'(rec0[2]), 32'h00);
    check_eq("lz_d3", 32'(rec0[3]), 32'h00);
    pulse_load(16'h0000, 4'h0);
    clear_rec();
    repeat (20) step();
    check_eq("zero_d0", 32'(rec0[0]), 32'h3F);
    check_eq("zero_d1", 32'(rec0[1]), 32'h00);
    check_eq("zero_d3", 32'(rec0[3]), 32'h00);
    blank_lz = 1'b0;
    repeat (40) step();

    // Frame-synchronous load: last of two mid-frame loads wins at the wrap.
    wait_phase(4);
    pulse_load(16'h1111, 4'h0);
    step();
    pulse_load(16'h2222, 4'h0);
    step();
    check_eq("sync_hold", 32'(seg1), 32'h3F);
    clear_rec();
    repeat (32) step();
    for (int i = 0; i < 4; i++) check_eq($sformatf("sync_d%0d", i), 32'(rec1[i]), 32'h5B);

    // Active-low pins with an all-segments digit and decimal points.
    pulse_load(16'h8888, 4'hF);
    repeat (10) step();
    check_eq("al_seg", 32'(seg2), 32'h00);
    check_eq("al_dp", 32'(dp2), 32'h0);
    check_eq("al_an_ones", 32'($countones(an2)), 32'd2);

    // Reset while a pending load is parked and idx = 2.
    pulse_load(16'h0000, 4'h0);
    repeat (20) step();
    wait_phase(2);
    pulse_load(16'h3333, 4'h0);
    wait_phase(8);
    reset = 1'b1;
    step();
    check_eq("midrst_seg1", 32'(seg1), 32'h00);
    check_eq("midrst_an1", 32'(an1), 32'h0);
    reset = 1'b0;
    step();
    check_eq("post_rst_an1", 32'(an1), 32'h1);
    check_eq("post_rst_seg1", 32'(seg1), 32'h3F);
    clear_rec();
    repeat (40) step();
    for (int i = 0; i < 4; i++) check_eq($sformatf("no_stale_d%0d", i), 32'(rec1[i]), 32'h3F);

    // Every hex code on the single-digit instance.
    for (int n = 0; n < 16; n++) begin
      pulse_load(16'(n), 4'h0);
      repeat (2) step();
      check_eq($sformatf("code_%0h", n), 32'(seg3), 32'(seg_tab[n]));
      check_eq("d1_an", 32'(an3), 32'h1);
    end

    // Randomized phase.
    for (int i = 0; i < 1500; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      load  = ($urandom_range(0, 5) == 0);
      if (load) begin
        value = 16'($urandom) >> (4 * $urandom_range(0, 4));
        dp_in = 4'($urandom);
      end
      if ($urandom_range(0, 30) == 0) blank_lz = ~blank_lz;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
